// File: rtl/mod10_count_decoder.sv
// mod10_count_decoder
//
// Receiving-end decoder for the BCD stream of the MOD10 up/down counter.
// Samples the counter digit, infers the counting direction from consecutive
// samples, rebuilds the tens digit from 9->0 carries and 0->9 borrows, and
// flags any transition the counter cannot legally produce.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   amostra_en   sample strobe; contador_in is evaluated only when 1
//   contador_in  BCD digit from the counter (legal 0..9)
//   unidade      last accepted units digit
//   dezena       reconstructed tens digit (BCD)
//   direcao      last inferred direction, 0 = up, 1 = down
//   valido       1 while locked and tracking
//   vai_um       one-cycle pulse on an accepted 9->0 up step
//   empresta     one-cycle pulse on an accepted 0->9 down step
//   erro         1 while in the error state
//
// Configuration macro:
//   MOD10_DEC_RESYNC_EN  defined: the error state is left on the next enabled
//                        legal sample (captured, back to LOCK, tens kept).
//                        undefined: the error state is sticky until reset.

module mod10_count_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       amostra_en,
    input  logic [3:0] contador_in,
    output logic [3:0] unidade,
    output logic [3:0] dezena,
    output logic       direcao,
    output logic       valido,
    output logic       vai_um,
    output logic       empresta,
    output logic       erro
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        TRACK,
        ERR
    } state_t;

    state_t     state;

    logic [3:0] u_succ;
    logic [3:0] u_pred;
    logic [3:0] d_succ;
    logic [3:0] d_pred;
    logic       legal;
    logic       is_hold;
    logic       is_up;
    logic       is_down;

    // Mod-10 neighbours of the held digits and classification of the sample.
    always_comb begin
        u_succ  = (unidade == 4'd9) ? 4'd0 : unidade + 4'd1;
        u_pred  = (unidade == 4'd0) ? 4'd9 : unidade - 4'd1;
        d_succ  = (dezena  == 4'd9) ? 4'd0 : dezena  + 4'd1;
        d_pred  = (dezena  == 4'd0) ? 4'd9 : dezena  - 4'd1;
        legal   = (contador_in <= 4'd9);
        is_hold = legal && (contador_in == unidade);
        is_up   = legal && (contador_in == u_succ);
        is_down = legal && (contador_in == u_pred);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            unidade  <= '0;
            dezena   <= '0;
            direcao  <= 1'b0;
            valido   <= 1'b0;
            vai_um   <= 1'b0;
            empresta <= 1'b0;
            erro     <= 1'b0;
        end else begin
            // Wrap pulses last exactly one cycle.
            vai_um   <= 1'b0;
            empresta <= 1'b0;

            if (amostra_en) begin
                unique case (state)
                    IDLE: begin
                        if (legal) begin
                            unidade <= contador_in;
                            state   <= LOCK;
                        end else begin
                            state   <= ERR;
                            erro    <= 1'b1;
                        end
                    end

                    LOCK, TRACK: begin
                        if (is_hold) begin
                            // Counter paused: nothing changes.
                        end else if (is_up) begin
                            unidade <= contador_in;
                            direcao <= 1'b0;
                            state   <= TRACK;
                            valido  <= 1'b1;
                            // A successor step from 9 can only be 9->0.
                            if (unidade == 4'd9) begin
                                dezena <= d_succ;
                                vai_um <= 1'b1;
                            end
                        end else if (is_down) begin
                            unidade <= contador_in;
                            direcao <= 1'b1;
                            state   <= TRACK;
                            valido  <= 1'b1;
                            // A predecessor step from 0 can only be 0->9.
                            if (unidade == 4'd0) begin
                                dezena   <= d_pred;
                                empresta <= 1'b1;
                            end
                        end else begin
                            state  <= ERR;
                            valido <= 1'b0;
                            erro   <= 1'b1;
                        end
                    end

                    ERR: begin
`ifdef MOD10_DEC_RESYNC_EN
                        if (legal) begin
                            unidade <= contador_in;
                            state   <= LOCK;
                            erro    <= 1'b0;
                        end
`endif
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod10_count_decoder.sv
// Directed bench for mod10_count_decoder. A behavioural model computes the
// expected outputs when each stimulus cycle is driven; the expectation is
// queued and compared after the capturing clock edge.

module tb_mod10_count_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       amostra_en;
    logic [3:0] contador_in;
    logic [3:0] unidade;
    logic [3:0] dezena;
    logic       direcao;
    logic       valido;
    logic       vai_um;
    logic       empresta;
    logic       erro;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [3:0] u;
        logic [3:0] d;
        logic       dir;
        logic       val;
        logic       vai;
        logic       emp;
        logic       err;
    } exp_t;

    exp_t q[$];

    // Model state: 0 idle, 1 lock, 2 track, 3 error.
    int m_st  = 0;
    int m_u   = 0;
    int m_d   = 0;
    int m_dir = 0;
    int m_vai = 0;
    int m_emp = 0;

    mod10_count_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .amostra_en  (amostra_en),
        .contador_in (contador_in),
        .unidade     (unidade),
        .dezena      (dezena),
        .direcao     (direcao),
        .valido      (valido),
        .vai_um      (vai_um),
        .empresta    (empresta),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit rst_n, input bit en, input int v);
        m_vai = 0;
        m_emp = 0;
        if (!rst_n) begin
            m_st = 0; m_u = 0; m_d = 0; m_dir = 0;
        end else if (en) begin
            if (m_st == 0) begin
                if (v < 10) begin m_u = v; m_st = 1; end
                else m_st = 3;
            end else if (m_st == 1 || m_st == 2) begin
                if (v >= 10) m_st = 3;
                else if (v == m_u) begin end
                else if (v == (m_u + 1) % 10) begin
                    if (m_u == 9) begin m_d = (m_d + 1) % 10; m_vai = 1; end
                    m_u = v; m_dir = 0; m_st = 2;
                end else if (v == (m_u + 9) % 10) begin
                    if (m_u == 0) begin m_d = (m_d + 9) % 10; m_emp = 1; end
                    m_u = v; m_dir = 1; m_st = 2;
                end else m_st = 3;
            end else begin
`ifdef MOD10_DEC_RESYNC_EN
                if (v < 10) begin m_u = v; m_st = 1; end
`endif
            end
        end
    endtask

    // Drive one cycle, queue the model's expectation, compare after the edge.
    task automatic cyc(input bit rst_n, input bit en, input int v);
        exp_t e;
        reset       = rst_n;
        amostra_en  = en;
        contador_in = 4'(v);
        model(rst_n, en, v);
        e.u   = 4'(m_u);
        e.d   = 4'(m_d);
        e.dir = (m_dir != 0);
        e.val = (m_st == 2);
        e.vai = (m_vai != 0);
        e.emp = (m_emp != 0);
        e.err = (m_st == 3);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("unidade",  unidade,         e.u);
        chk("dezena",   dezena,          e.d);
        chk("direcao",  {3'b0, direcao}, {3'b0, e.dir});
        chk("valido",   {3'b0, valido},  {3'b0, e.val});
        chk("vai_um",   {3'b0, vai_um},  {3'b0, e.vai});
        chk("empresta", {3'b0, empresta},{3'b0, e.emp});
        chk("erro",     {3'b0, erro},    {3'b0, e.err});
    endtask

    task automatic sample(input int v);
        cyc(1'b1, 1'b1, v);
    endtask

    task automatic do_reset();
        // Strobe held high with a legal code to show reset has priority.
        cyc(1'b0, 1'b1, 3);
        cyc(1'b1, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b0; amostra_en = 1'b0; contador_in = 4'd0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_unidade", unidade, 4'd0);
        chk("rst_erro",    {3'b0, erro}, 4'd0);

        // Up sweep with carry.
        sample(7); sample(8);
        chk("up_valido", {3'b0, valido}, 4'd1);
        chk("up_dir",    {3'b0, direcao}, 4'd0);
        sample(9); sample(0);
        chk("up_vai_um", {3'b0, vai_um}, 4'd1);
        chk("up_dezena", dezena, 4'd1);
        sample(1);
        chk("up_vai_fall", {3'b0, vai_um}, 4'd0);
        chk("up_unidade", unidade, 4'd1);

        // Down sweep with borrow.
        do_reset();
        sample(1); sample(0);
        sample(9);
        chk("dn_empresta", {3'b0, empresta}, 4'd1);
        chk("dn_dezena",   dezena, 4'd9);
        chk("dn_unidade",  unidade, 4'd9);
        chk("dn_dir",      {3'b0, direcao}, 4'd1);
        sample(8);

        // Reversal and hold.
        do_reset();
        sample(3); sample(4); sample(4); sample(4);
        chk("hold_valido", {3'b0, valido}, 4'd1);
        sample(3);
        chk("rev_dir", {3'b0, direcao}, 4'd1);
        chk("rev_unidade", unidade, 4'd3);

        // Illegal jump.
        do_reset();
        sample(2); sample(3); sample(6);
        chk("jmp_erro",    {3'b0, erro}, 4'd1);
        chk("jmp_valido",  {3'b0, valido}, 4'd0);
        chk("jmp_unidade", unidade, 4'd3);
        sample(7);
`ifdef MOD10_DEC_RESYNC_EN
        chk("resync_erro",    {3'b0, erro}, 4'd0);
        chk("resync_unidade", unidade, 4'd7);
        sample(12);
        sample(13);
        sample(6);
        sample(5);
        chk("resync_track", {3'b0, valido}, 4'd1);
`else
        chk("sticky_erro",    {3'b0, erro}, 4'd1);
        chk("sticky_unidade", unidade, 4'd3);
        sample(8);
`endif

        // Illegal code in IDLE.
        do_reset();
        sample(12);
        chk("code_erro", {3'b0, erro}, 4'd1);

        // Strobe gating.
        do_reset();
        sample(4); sample(5);
        cyc(1'b1, 1'b0, 5); cyc(1'b1, 1'b0, 9); cyc(1'b1, 1'b0, 2);
        chk("gate_unidade", unidade, 4'd5);
        chk("gate_valido",  {3'b0, valido}, 4'd1);
        // Wrap pulse must not appear while the strobe is low.
        sample(6); sample(7); sample(8); sample(9);
        cyc(1'b1, 1'b0, 0);
        chk("gate_vai", {3'b0, vai_um}, 4'd0);
        sample(0);
        chk("gate_vai_en", {3'b0, vai_um}, 4'd1);

        // Reset mid-operation after two carries.
        do_reset();
        sample(8); sample(9); sample(0);
        for (int unsigned i = 1; i <= 9; i++) sample(int'(i));
        sample(0);
        chk("mid_dezena", dezena, 4'd2);
        cyc(1'b0, 1'b1, 1);
        chk("mid_rst_dezena", dezena, 4'd0);
        chk("mid_rst_valido", {3'b0, valido}, 4'd0);
        sample(5);
        chk("mid_cap_unidade", unidade, 4'd5);
        chk("mid_cap_valido",  {3'b0, valido}, 4'd0);
        sample(4);
        sample(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
